clint: RTL and testbench
========================

// Module: clint
// PURPOSE
//  Core-local interruptor: 64-bit mtime/mtimecmp timer plus MSIP software-interrupt register behind a simple
//  single-outstanding register bus. Drives the timer/software interrupt request levels into interrupt_interface
//  and consumes its per-source acks. Sits directly upstream of interrupt_interface.
// PARAMETERS
//  TICK_DIV          1  clk cycles per mtime increment (>=1); prescaler counts 0..TICK_DIV-1
//  AUTO_CLEAR_MSIP   1  1: intif_all_int_software_ack clears MSIP; 0: ack ignored, software clears MSIP
// PORTS
//  clk                          input   1   core clock
//  rst                          input   1   asynchronous, active-low reset
//  bus_clint_req                input   1   register access request, 1-cycle pulse, ignored while busy
//  bus_clint_we                 input   1   1 = write, 0 = read
//  bus_clint_addr               input   16  byte offset, word aligned
//  bus_clint_wdata              input   32  write data
//  clint_bus_ack                output  1   1-cycle completion pulse, cycle after accepted req
//  clint_bus_rdata              output  32  read data, valid with ack (0 for writes)
//  clint_bus_err                output  1   with ack: unmapped or misaligned address
//  all_intif_int_timer_req      output  1   level: mtime >= mtimecmp
//  all_intif_int_software_req   output  1   level: MSIP bit
//  intif_all_int_timer_ack      input   1   timer interrupt taken (pulse)
//  intif_all_int_software_ack   input   1   software interrupt taken (pulse)
// BEHAVIOUR
//  Register map (32-bit): 0x0000 MSIP (bit0 only, bits31:1 read 0); 0x4000 MTIMECMP[31:0]; 0x4004 MTIMECMP[63:32];
//   0xBFF8 MTIME[31:0]; 0xBFFC MTIME[63:32]. Any other offset or addr[1:0]!=0 -> err.
//  Reset (rst=0, async): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0, busy=0;
//   all outputs 0. Release is synchronous to clk; first tick TICK_DIV cycles after release.
//  Bus FSM: IDLE -> (req) -> RESP -> IDLE. Req sampled in IDLE only; in RESP the req is dropped (no queuing).
//   RESP cycle: ack=1, rdata/err registered from the request cycle's state. Back-to-back req accepted the cycle after ack.
//   Write commits at end of request cycle; err access: write ignored, rdata=0, err=1.
//  Read of MTIME lo/hi returns the value at the request edge; no hi/lo atomic latch (software re-reads hi).
//  mtime: prescaler wraps at TICK_DIV-1 producing tick; tick increments mtime by 1, 64-bit, 2^64-1 wraps to 0.
//   Write to MTIME lo or hi in a tick cycle: written half takes wdata, other half keeps its current value,
//   no increment that cycle; prescaler not reset by writes.
//  timer_req: registered, = (mtime >= mtimecmp) unsigned 64-bit from current regs; 1-cycle lag after any
//   mtime/mtimecmp change. Cleared only by raising mtimecmp or lowering mtime; timer ack has no state effect.
//  software_req: = msip register directly (registered output). MSIP write takes wdata[0] next cycle.
//  Software ack with AUTO_CLEAR_MSIP=1: msip<=0 next cycle. Same cycle as MSIP write: write wins.
//  Reset mid-RESP: ack suppressed, no response issued after release.
// TESTING
//  1 Reset: hold rst=0 5 cycles -> all outputs 0; read 0x4004 after release -> rdata=32'hFFFF_FFFF, ack 1 cycle later.
//  2 TICK_DIV=4: write MTIMECMP hi=0, lo=10 -> timer_req rises exactly 1 cycle after mtime reaches 10
//    (~40 cycles); write MTIMECMP lo=100 -> timer_req 0 next cycle; timer ack pulse -> no change.
//  3 Write MSIP=1 -> software_req=1 next cycle; software ack -> 0 next cycle (AUTO_CLEAR_MSIP=1);
//    with AUTO_CLEAR_MSIP=0 stays 1 until MSIP write 0; ack + MSIP=1 write same cycle -> stays 1.
//  4 Wrap: write MTIME hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFE -> after 2 ticks reads lo=0, hi=0; with mtimecmp=0
//    timer_req remains 1 through wrap.
//  5 Write MTIME lo=5 on a tick cycle -> read lo=5 (no +1); req while RESP -> dropped, single ack;
//    read 0x0010 -> ack=1, err=1, rdata=0.
//  6 Assert rst=0 during RESP of a read -> no ack, registers back to reset values, next read completes normally.

Source files
------------

// File: rtl/clint_if.sv
// ---------------------------------------------------------------------------
// clint_if -- register bus between a bus master and the CLINT.
//   Single-outstanding request/response:
//     bus_clint_req    master->slave  1   request pulse
//     bus_clint_we     master->slave  1   1 = write, 0 = read
//     bus_clint_addr   master->slave  16  byte offset, word aligned
//     bus_clint_wdata  master->slave  32  write data
//     clint_bus_ack    slave->master  1   completion pulse
//     clint_bus_rdata  slave->master  32  read data (valid with ack)
//     clint_bus_err    slave->master  1   error flag (valid with ack)
// ---------------------------------------------------------------------------
interface clint_if;
  logic        bus_clint_req;
  logic        bus_clint_we;
  logic [15:0] bus_clint_addr;
  logic [31:0] bus_clint_wdata;
  logic        clint_bus_ack;
  logic [31:0] clint_bus_rdata;
  logic        clint_bus_err;

  modport master (
    output bus_clint_req, bus_clint_we, bus_clint_addr, bus_clint_wdata,
    input  clint_bus_ack, clint_bus_rdata, clint_bus_err
  );

  modport slave (
    input  bus_clint_req, bus_clint_we, bus_clint_addr, bus_clint_wdata,
    output clint_bus_ack, clint_bus_rdata, clint_bus_err
  );
endinterface

// File: rtl/clint.sv
// ---------------------------------------------------------------------------
// clint -- core-local interruptor.
//   64-bit mtime/mtimecmp timer and MSIP software-interrupt bit behind a
//   single-outstanding register bus. Drives timer/software interrupt request
//   levels and consumes per-source acks.
// Ports:
//   clk                         core clock
//   rst                         asynchronous active-low reset
//   bus                         register bus (clint_if.slave)
//   all_intif_int_timer_req     level: mtime >= mtimecmp (registered)
//   all_intif_int_software_req  level: MSIP bit
//   intif_all_int_timer_ack     timer interrupt taken (no state effect)
//   intif_all_int_software_ack  software interrupt taken (clears MSIP when
//                               AUTO_CLEAR_MSIP=1)
// Register map: 0x0000 MSIP, 0x4000/0x4004 MTIMECMP lo/hi,
//               0xBFF8/0xBFFC MTIME lo/hi; anything else -> err.
// ---------------------------------------------------------------------------
module clint #(
  parameter int unsigned TICK_DIV        = 1,
  parameter bit          AUTO_CLEAR_MSIP = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  clint_if.slave   bus,
  output logic     all_intif_int_timer_req,
  output logic     all_intif_int_software_req,
  input  logic     intif_all_int_timer_ack,
  input  logic     intif_all_int_software_ack
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [15:0] ADDR_MSIP       = 16'h0000;
  localparam logic [15:0] ADDR_MTIMECMP_L = 16'h4000;
  localparam logic [15:0] ADDR_MTIMECMP_H = 16'h4004;
  localparam logic [15:0] ADDR_MTIME_L    = 16'hBFF8;
  localparam logic [15:0] ADDR_MTIME_H    = 16'hBFFC;

  typedef enum logic {
    S_IDLE,
    S_RESP
  } bus_state_t;

  bus_state_t    state, state_next;

  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic          msip;
  logic [PW-1:0] presc;
  logic          tick;
  logic          timer_req_q;

  logic [31:0]   rdata_q;
  logic          err_q;

  logic          accept;
  logic [31:0]   rd_data;
  logic          rd_err;
  logic          wr_ok;
  logic          we_msip;
  logic          we_cmp_lo;
  logic          we_cmp_hi;
  logic          we_time_lo;
  logic          we_time_hi;

  // Timer acks are informational only; the request clears via register writes.
  logic          unused_timer_ack;
  assign unused_timer_ack = intif_all_int_timer_ack;

  // ---------------------------------------------------------------- bus FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.bus_clint_req) begin
          accept     = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        // Requests arriving here are dropped, not queued.
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------- address decode
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (bus.bus_clint_addr)
      ADDR_MSIP:       rd_data = {31'b0, msip};
      ADDR_MTIMECMP_L: rd_data = mtimecmp[31:0];
      ADDR_MTIMECMP_H: rd_data = mtimecmp[63:32];
      ADDR_MTIME_L:    rd_data = mtime[31:0];
      ADDR_MTIME_H:    rd_data = mtime[63:32];
      default:         rd_err  = 1'b1;
    endcase
  end

  always_comb begin
    wr_ok      = accept && bus.bus_clint_we && !rd_err;
    we_msip    = wr_ok && (bus.bus_clint_addr == ADDR_MSIP);
    we_cmp_lo  = wr_ok && (bus.bus_clint_addr == ADDR_MTIMECMP_L);
    we_cmp_hi  = wr_ok && (bus.bus_clint_addr == ADDR_MTIMECMP_H);
    we_time_lo = wr_ok && (bus.bus_clint_addr == ADDR_MTIME_L);
    we_time_hi = wr_ok && (bus.bus_clint_addr == ADDR_MTIME_H);
  end

  // Response is captured from the request-cycle state and shown in RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= (accept && !bus.bus_clint_we && !rd_err) ? rd_data : '0;
      err_q   <= accept && rd_err;
    end
  end

  assign bus.clint_bus_ack   = (state == S_RESP);
  assign bus.clint_bus_rdata = rdata_q;
  assign bus.clint_bus_err   = err_q;

  // ------------------------------------------------------------------ timer
  assign tick = (presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // A write to either half suppresses that cycle's increment; the other
  // half keeps its pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime <= '0;
    end else if (we_time_lo) begin
      mtime <= {mtime[63:32], bus.bus_clint_wdata};
    end else if (we_time_hi) begin
      mtime <= {bus.bus_clint_wdata, mtime[31:0]};
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtimecmp <= '1;
    end else if (we_cmp_lo) begin
      mtimecmp <= {mtimecmp[63:32], bus.bus_clint_wdata};
    end else if (we_cmp_hi) begin
      mtimecmp <= {bus.bus_clint_wdata, mtimecmp[31:0]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_req_q <= 1'b0;
    end else begin
      timer_req_q <= (mtime >= mtimecmp);
    end
  end

  assign all_intif_int_timer_req = timer_req_q;

  // ------------------------------------------------------------------- MSIP
  // A bus write in the same cycle as the ack takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msip <= 1'b0;
    end else if (we_msip) begin
      msip <= bus.bus_clint_wdata[0];
    end else if (AUTO_CLEAR_MSIP && intif_all_int_software_ack) begin
      msip <= 1'b0;
    end
  end

  assign all_intif_int_software_req = msip;

endmodule

// File: tb/tb_clint.sv
module tb_clint;

  logic        clk;
  logic        rst;
  logic        t_ack, s_ack, timer_req, sw_req;
  logic        t_ack2, s_ack2, timer_req2, sw_req2;
  int unsigned edge_cnt;
  int          checks;
  int          errors;

  clint_if bif ();
  clint_if bif2 ();

  clint #(.TICK_DIV(4), .AUTO_CLEAR_MSIP(1'b1)) u_dut (
    .clk                        (clk),
    .rst                        (rst),
    .bus                        (bif.slave),
    .all_intif_int_timer_req    (timer_req),
    .all_intif_int_software_req (sw_req),
    .intif_all_int_timer_ack    (t_ack),
    .intif_all_int_software_ack (s_ack)
  );

  clint #(.TICK_DIV(1), .AUTO_CLEAR_MSIP(1'b0)) u_dut_nc (
    .clk                        (clk),
    .rst                        (rst),
    .bus                        (bif2.slave),
    .all_intif_int_timer_req    (timer_req2),
    .all_intif_int_software_req (sw_req2),
    .intif_all_int_timer_ack    (t_ack2),
    .intif_all_int_software_ack (s_ack2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge number since reset release; with TICK_DIV=4 mtime advances on
  // edges whose number is a multiple of 4.
  always @(posedge clk or negedge rst) begin
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
    $fatal(1, "watchdog");
  end

  // One access on the main DUT, starting just after a posedge. Returns the
  // response seen in the RESP cycle and the accept edge number; ends back in
  // IDLE just after a posedge.
  task automatic do_access(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output logic ack,
                           output int unsigned acc_edge);
    bif.bus_clint_req   = 1'b1;
    bif.bus_clint_we    = we;
    bif.bus_clint_addr  = addr;
    bif.bus_clint_wdata = wdata;
    @(posedge clk); #1;
    bif.bus_clint_req = 1'b0;
    acc_edge = edge_cnt;
    ack   = bif.clint_bus_ack;
    rdata = bif.clint_bus_rdata;
    err   = bif.clint_bus_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic [31:0] rd; logic er, ak; int unsigned ae;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({bif.clint_bus_ack, bif.clint_bus_err, timer_req, sw_req} !== 4'b0 || bif.clint_bus_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ack/err/treq/sreq=%b rdata=%h, expected 0000 and 0",
               {bif.clint_bus_ack, bif.clint_bus_err, timer_req, sw_req}, bif.clint_bus_rdata);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    do_access(1'b0, 16'h4004, 32'h0, rd, er, ak, ae);
    checks++;
    if (ak !== 1'b1 || er !== 1'b0 || rd !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_mtimecmp_hi: ack=%b err=%b rdata=%h, expected 1 0 ffffffff", ak, er, rd);
    end
  endtask

  task automatic test_timer;
    logic [31:0] rd; logic er, ak; int unsigned ae, a0, e, cnt, exp_e, seen;
    logic found;
    do_access(1'b1, 16'h4004, 32'h0, rd, er, ak, ae);
    do_access(1'b1, 16'hBFFC, 32'h0, rd, er, ak, ae);
    do_access(1'b1, 16'hBFF8, 32'h0, rd, er, ak, a0);
    do_access(1'b1, 16'h4000, 32'd10, rd, er, ak, ae);
    cnt = 0; e = a0;
    while (cnt < 10) begin
      e++;
      if (e % 4 == 0) cnt++;
    end
    exp_e = e + 1;
    found = 1'b0; seen = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (timer_req === 1'b1) begin
        found = 1'b1;
        seen  = edge_cnt;
      end else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!found || seen != exp_e) begin
      errors++;
      $display("FAIL timer_rise_edge: found=%b edge=%0d, expected edge %0d", found, seen, exp_e);
    end
    do_access(1'b0, 16'hBFF8, 32'h0, rd, er, ak, ae);
    checks++;
    if (rd !== 32'd10) begin
      errors++;
      $display("FAIL timer_mtime_at_rise: mtime lo=%0d, expected 10", rd);
    end
    do_access(1'b1, 16'h4000, 32'd100, rd, er, ak, ae);
    checks++;
    if (timer_req !== 1'b0) begin
      errors++;
      $display("FAIL timer_clear_raise_cmp: timer_req=%b, expected 0", timer_req);
    end
    do_access(1'b1, 16'h4000, 32'd0, rd, er, ak, ae);
    t_ack = 1'b1;
    @(posedge clk); #1;
    t_ack = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (timer_req !== 1'b1) begin
      errors++;
      $display("FAIL timer_ack_no_effect: timer_req=%b, expected 1", timer_req);
    end
  endtask

  task automatic test_msip;
    logic [31:0] rd; logic er, ak; int unsigned ae;
    do_access(1'b1, 16'h0000, 32'h1, rd, er, ak, ae);
    checks++;
    if (sw_req !== 1'b1) begin
      errors++;
      $display("FAIL msip_set: software_req=%b, expected 1", sw_req);
    end
    do_access(1'b0, 16'h0000, 32'h0, rd, er, ak, ae);
    checks++;
    if (rd !== 32'h1 || er !== 1'b0) begin
      errors++;
      $display("FAIL msip_read: rdata=%h err=%b, expected 00000001 0", rd, er);
    end
    s_ack = 1'b1;
    @(posedge clk); #1;
    s_ack = 1'b0;
    checks++;
    if (sw_req !== 1'b0) begin
      errors++;
      $display("FAIL msip_auto_clear: software_req=%b, expected 0", sw_req);
    end
    // Ack and MSIP=1 write land on the same edge: the write must win.
    bif.bus_clint_req   = 1'b1;
    bif.bus_clint_we    = 1'b1;
    bif.bus_clint_addr  = 16'h0000;
    bif.bus_clint_wdata = 32'h1;
    s_ack = 1'b1;
    @(posedge clk); #1;
    bif.bus_clint_req = 1'b0;
    s_ack = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (sw_req !== 1'b1) begin
      errors++;
      $display("FAIL msip_write_beats_ack: software_req=%b, expected 1", sw_req);
    end
    s_ack = 1'b1;
    @(posedge clk); #1;
    s_ack = 1'b0;

    // Second instance without auto-clear.
    bif2.bus_clint_req   = 1'b1;
    bif2.bus_clint_we    = 1'b1;
    bif2.bus_clint_addr  = 16'h0000;
    bif2.bus_clint_wdata = 32'h1;
    @(posedge clk); #1;
    bif2.bus_clint_req = 1'b0;
    @(posedge clk); #1;
    s_ack2 = 1'b1;
    @(posedge clk); #1;
    s_ack2 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (sw_req2 !== 1'b1) begin
      errors++;
      $display("FAIL msip_no_auto_clear: software_req=%b, expected 1", sw_req2);
    end
    bif2.bus_clint_req   = 1'b1;
    bif2.bus_clint_wdata = 32'h0;
    @(posedge clk); #1;
    bif2.bus_clint_req = 1'b0;
    checks++;
    if (sw_req2 !== 1'b0) begin
      errors++;
      $display("FAIL msip_sw_clear: software_req=%b, expected 0", sw_req2);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] rd_lo, rd_hi; logic er, ak, dropped; int unsigned ae, n;
    // mtimecmp is 0 here, so the timer request must hold across the wrap.
    do_access(1'b1, 16'hBFFC, 32'hFFFF_FFFF, rd_lo, er, ak, ae);
    do_access(1'b1, 16'hBFF8, 32'hFFFF_FFFE, rd_lo, er, ak, ae);
    dropped = 1'b0; n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      @(posedge clk); #1;
      if (timer_req !== 1'b1) dropped = 1'b1;
      if (edge_cnt % 4 == 0) n++;
    end
    do_access(1'b0, 16'hBFF8, 32'h0, rd_lo, er, ak, ae);
    do_access(1'b0, 16'hBFFC, 32'h0, rd_hi, er, ak, ae);
    checks++;
    if (rd_lo !== 32'h0 || rd_hi !== 32'h0) begin
      errors++;
      $display("FAIL wrap_value: hi=%h lo=%h, expected 00000000 00000000", rd_hi, rd_lo);
    end
    checks++;
    if (dropped !== 1'b0 || timer_req !== 1'b1) begin
      errors++;
      $display("FAIL wrap_timer_req: dropped=%b now=%b, expected 0 1", dropped, timer_req);
    end
  endtask

  task automatic test_bus_edges;
    logic [31:0] rd; logic er, ak; int unsigned ae, acks;
    for (int i = 0; i < 8 && (edge_cnt % 4) != 3; i++) begin
      @(posedge clk); #1;
    end
    do_access(1'b1, 16'hBFF8, 32'd5, rd, er, ak, ae);
    do_access(1'b0, 16'hBFF8, 32'h0, rd, er, ak, ae);
    checks++;
    if (rd !== 32'd5) begin
      errors++;
      $display("FAIL tick_write_no_inc: mtime lo=%0d, expected 5", rd);
    end
    // Second pulse lands in RESP and must be dropped.
    acks = 0;
    bif.bus_clint_req  = 1'b1;
    bif.bus_clint_we   = 1'b0;
    bif.bus_clint_addr = 16'h0000;
    @(posedge clk); #1;
    if (bif.clint_bus_ack === 1'b1) acks++;
    @(posedge clk); #1;
    bif.bus_clint_req = 1'b0;
    if (bif.clint_bus_ack === 1'b1) acks++;
    repeat (2) begin
      @(posedge clk); #1;
      if (bif.clint_bus_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 1) begin
      errors++;
      $display("FAIL req_in_resp_dropped: acks=%0d, expected 1", acks);
    end
    do_access(1'b0, 16'h0010, 32'h0, rd, er, ak, ae);
    checks++;
    if (ak !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_read: ack=%b err=%b rdata=%h, expected 1 1 00000000", ak, er, rd);
    end
    do_access(1'b0, 16'h4002, 32'h0, rd, er, ak, ae);
    checks++;
    if (ak !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL misaligned_read: ack=%b err=%b rdata=%h, expected 1 1 00000000", ak, er, rd);
    end
  endtask

  task automatic test_reset_in_resp;
    logic [31:0] rd; logic er, ak; int unsigned ae, acks;
    bif.bus_clint_req  = 1'b1;
    bif.bus_clint_we   = 1'b0;
    bif.bus_clint_addr = 16'h4004;
    @(posedge clk); #1;
    bif.bus_clint_req = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (bif.clint_bus_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_kills_ack: ack=%b, expected 0", bif.clint_bus_ack);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    acks = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bif.clint_bus_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL no_ack_after_release: acks=%0d, expected 0", acks);
    end
    do_access(1'b0, 16'h4004, 32'h0, rd, er, ak, ae);
    checks++;
    if (ak !== 1'b1 || er !== 1'b0 || rd !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL read_after_reset: ack=%b err=%b rdata=%h, expected 1 0 ffffffff", ak, er, rd);
    end
    checks++;
    if (timer_req !== 1'b0 || sw_req !== 1'b0) begin
      errors++;
      $display("FAIL irq_after_reset: treq=%b sreq=%b, expected 0 0", timer_req, sw_req);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    t_ack = 1'b0; s_ack = 1'b0; t_ack2 = 1'b0; s_ack2 = 1'b0;
    bif.bus_clint_req = 1'b0;  bif.bus_clint_we = 1'b0;
    bif.bus_clint_addr = '0;   bif.bus_clint_wdata = '0;
    bif2.bus_clint_req = 1'b0; bif2.bus_clint_we = 1'b0;
    bif2.bus_clint_addr = '0;  bif2.bus_clint_wdata = '0;
    #1;
    test_reset();
    test_timer();
    test_msip();
    test_wrap();
    test_bus_edges();
    test_reset_in_resp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
